// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifetch_pkg;

    // Canonical NOP (addi x0, x0, 0), presented for empty slots and faulted fetches
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Entry field widths (the PC / exception value width is the XLEN parameter)
    localparam int INSTR_W    = 32;
    localparam int EXC_CODE_W = 4;

    // Fetch-side exception causes
    localparam logic [EXC_CODE_W-1:0] EXC_INSTR_MISALIGNED = 4'd0;
    localparam logic [EXC_CODE_W-1:0] EXC_INSTR_ACCESS     = 4'd1;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        MISAL = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // A fetch target is misaligned when it is not on a 4-byte boundary
    function automatic logic is_misaligned(input logic [1:0] pc_low);
        return pc_low != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO holding fetched entries; head is read combinationally
// from registered storage and reads as a NOP with no exception when empty.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [XLEN-1:0]       push_pc,
    input  logic [INSTR_W-1:0]    push_instr,
    input  logic                  push_exc_en,
    input  logic [EXC_CODE_W-1:0] push_exc_code,
    input  logic [XLEN-1:0]       push_exc_val,
    output logic [CNT_W-1:0]      count,
    output logic                  head_valid,
    output logic [XLEN-1:0]       head_pc,
    output logic [INSTR_W-1:0]    head_instr,
    output logic                  head_exc_en,
    output logic [EXC_CODE_W-1:0] head_exc_code,
    output logic [XLEN-1:0]       head_exc_val
);

    logic [XLEN-1:0]       pc_mem       [DEPTH];
    logic [INSTR_W-1:0]    instr_mem    [DEPTH];
    logic                  exc_en_mem   [DEPTH];
    logic [EXC_CODE_W-1:0] exc_code_mem [DEPTH];
    logic [XLEN-1:0]       exc_val_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    // Flush overrides both push and pop for the cycle
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_reg != '0);

    // Entry storage: write-only at the tail, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr_reg]       <= push_pc;
            instr_mem[wr_ptr_reg]    <= push_instr;
            exc_en_mem[wr_ptr_reg]   <= push_exc_en;
            exc_code_mem[wr_ptr_reg] <= push_exc_code;
            exc_val_mem[wr_ptr_reg]  <= push_exc_val;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count = count_reg;

    // Head view: stored entry when occupied, zero/NOP otherwise
    always_comb begin
        head_valid    = (count_reg != '0);
        head_pc       = '0;
        head_instr    = NOP_INSTR;
        head_exc_en   = 1'b0;
        head_exc_code = '0;
        head_exc_val  = '0;
        if (head_valid) begin
            head_pc       = pc_mem[rd_ptr_reg];
            head_instr    = instr_mem[rd_ptr_reg];
            head_exc_en   = exc_en_mem[rd_ptr_reg];
            head_exc_code = exc_code_mem[rd_ptr_reg];
            head_exc_val  = exc_val_mem[rd_ptr_reg];
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, fetches from a combinational memory,
// buffers entries and hands them to decode over valid/ready.
// Optional build macro IFETCH_PERF_CNT_EN adds saturating perf counters.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int              XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [XLEN-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]    imem_instr,
    input  logic                  imem_exc_en,
    input  logic [EXC_CODE_W-1:0] imem_exc_code,
    input  logic [XLEN-1:0]       imem_exc_val,
    input  logic                  redirect_en,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [XLEN-1:0]       if_pc,
    output logic [INSTR_W-1:0]    if_instr,
    output logic                  if_exc_en,
    output logic [EXC_CODE_W-1:0] if_exc_code,
    output logic [XLEN-1:0]       if_exc_val
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [63:0]           perf_fetched,
    output logic [63:0]           perf_stall
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]  pc_reg;
    fetch_state_t     state_reg;
    logic [CNT_W-1:0] fifo_count;

    logic                  pop;
    logic                  push_ok;
    logic                  push;
    logic [INSTR_W-1:0]    push_instr;
    logic                  push_exc_en;
    logic [EXC_CODE_W-1:0] push_exc_code;
    logic [XLEN-1:0]       push_exc_val;

    assign imem_addr = pc_reg;
    assign pop       = if_valid && if_ready;
    assign push_ok   = (fifo_count < CNT_W'(FIFO_DEPTH)) || pop;

    // Select what (if anything) enters the buffer this cycle
    always_comb begin
        push          = 1'b0;
        push_instr    = NOP_INSTR;
        push_exc_en   = 1'b0;
        push_exc_code = '0;
        push_exc_val  = '0;
        if (!redirect_en && push_ok) begin
            case (state_reg)
                FETCH: begin
                    push = 1'b1;
                    if (imem_exc_en) begin
                        push_exc_en   = 1'b1;
                        push_exc_code = imem_exc_code;
                        push_exc_val  = imem_exc_val;
                    end else begin
                        push_instr = imem_instr;
                    end
                end
                MISAL: begin
                    push          = 1'b1;
                    push_exc_en   = 1'b1;
                    push_exc_code = EXC_INSTR_MISALIGNED;
                    push_exc_val  = pc_reg;
                end
                default: push = 1'b0;
            endcase
        end
    end

    // PC and sequencer: redirect beats everything but reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg    <= RESET_PC;
            state_reg <= FETCH;
        end else if (redirect_en) begin
            pc_reg    <= redirect_pc;
            state_reg <= is_misaligned(redirect_pc[1:0]) ? MISAL : FETCH;
        end else if (push) begin
            case (state_reg)
                FETCH: begin
                    if (imem_exc_en) begin
                        state_reg <= HOLD;
                    end else begin
                        pc_reg <= pc_reg + XLEN'(4);
                    end
                end
                MISAL:   state_reg <= HOLD;
                default: state_reg <= state_reg;
            endcase
        end
    end

    ifetch_fifo #(
        .XLEN  (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .flush         (redirect_en),
        .push_pc       (pc_reg),
        .push_instr    (push_instr),
        .push_exc_en   (push_exc_en),
        .push_exc_code (push_exc_code),
        .push_exc_val  (push_exc_val),
        .count         (fifo_count),
        .head_valid    (if_valid),
        .head_pc       (if_pc),
        .head_instr    (if_instr),
        .head_exc_en   (if_exc_en),
        .head_exc_code (if_exc_code),
        .head_exc_val  (if_exc_val)
    );

`ifdef IFETCH_PERF_CNT_EN
    logic [63:0] perf_fetched_reg;
    logic [63:0] perf_stall_reg;

    // Saturating counters of clean fetches and back-pressure stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (push && !push_exc_en && perf_fetched_reg != '1) begin
                perf_fetched_reg <= perf_fetched_reg + 64'd1;
            end
            if (!redirect_en && state_reg == FETCH && !push_ok && perf_stall_reg != '1) begin
                perf_stall_reg <= perf_stall_reg + 64'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with a 2048-word combinational memory model.
module tb_ifetch_unit;
    import ifetch_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_instr;
    logic            imem_exc_en;
    logic [3:0]      imem_exc_code;
    logic [XLEN-1:0] imem_exc_val;
    logic            redirect_en = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            if_valid;
    logic            if_ready = 1'b0;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            if_exc_en;
    logic [3:0]      if_exc_code;
    logic [XLEN-1:0] if_exc_val;
`ifdef IFETCH_PERF_CNT_EN
    logic [63:0]     perf_fetched;
    logic [63:0]     perf_stall;
`endif

    int n_vec     = 0;
    int n_miscmp  = 0;

    always #5 clk = ~clk;

    // Memory model: 2048 words (0x0..0x1FFC), fault above; instruction tagged by address
    always_comb begin
        imem_exc_en   = (imem_addr >= 64'h2000);
        imem_exc_code = imem_exc_en ? 4'd1 : 4'd0;
        imem_exc_val  = imem_exc_en ? imem_addr : 64'h0;
        imem_instr    = imem_exc_en ? 32'hDEADBEEF : (32'hA000_0000 | imem_addr[31:0]);
    end

    ifetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .imem_exc_en   (imem_exc_en),
        .imem_exc_code (imem_exc_code),
        .imem_exc_val  (imem_exc_val),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_exc_en     (if_exc_en),
        .if_exc_code   (if_exc_code),
        .if_exc_val    (if_exc_val)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one rising edge; return at the following falling edge for sampling/driving
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_en = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        // ---- Reset state ----
        if_ready = 1'b0;
        tick(1);
        check("rst_valid",    64'(if_valid),    64'd0);
        check("rst_pc",       if_pc,            64'h0);
        check("rst_instr",    64'(if_instr),    64'h13);
        check("rst_exc_en",   64'(if_exc_en),   64'd0);
        check("rst_exc_code", 64'(if_exc_code), 64'd0);
        check("rst_exc_val",  if_exc_val,       64'h0);
        check("rst_addr",     imem_addr,        64'h0);

        // ---- Streaming with decode always ready ----
        rst = 1'b0;
        if_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("stream_valid", 64'(if_valid), 64'd1);
            check("stream_pc",    if_pc,         64'(i * 4));
            check("stream_instr", 64'(if_instr), 64'hA000_0000 | 64'(i * 4));
            check("stream_addr",  imem_addr,     64'(i * 4 + 4));
        end

        // ---- Back-pressure from reset for 5 cycles ----
        if_ready = 1'b0;
        do_reset();
        tick(5);
        check("bp_valid", 64'(if_valid), 64'd1);
        check("bp_addr",  imem_addr,     64'h8);
`ifdef IFETCH_PERF_CNT_EN
        check("bp_perf_stall",   perf_stall,   64'd3);
        check("bp_perf_fetched", perf_fetched, 64'd2);
`endif
        if_ready = 1'b1;
        check("bp_pop0", if_pc, 64'h0);
        tick(1);
        check("bp_pop1", if_pc, 64'h4);
        tick(1);
        check("bp_pop2", if_pc, 64'h8);

        // ---- Redirect with a full buffer ----
        if_ready = 1'b0;
        tick(3);
        redirect_en = 1'b1;
        redirect_pc = 64'h100;
        tick(1);
        redirect_en = 1'b0;
        check("redir_flush_valid", 64'(if_valid), 64'd0);
        check("redir_addr",        imem_addr,     64'h100);
        if_ready = 1'b1;
        tick(1);
        check("redir_first_valid", 64'(if_valid), 64'd1);
        check("redir_first_pc",    if_pc,         64'h100);
        tick(1);
        check("redir_second_pc",   if_pc,         64'h104);

        // ---- Misaligned redirect ----
        redirect_en = 1'b1;
        redirect_pc = 64'h102;
        tick(1);
        redirect_en = 1'b0;
        check("misal_empty", 64'(if_valid), 64'd0);
        tick(1);
        check("misal_valid",    64'(if_valid),    64'd1);
        check("misal_pc",       if_pc,            64'h102);
        check("misal_exc_en",   64'(if_exc_en),   64'd1);
        check("misal_exc_code", 64'(if_exc_code), 64'd0);
        check("misal_exc_val",  if_exc_val,       64'h102);
        check("misal_instr",    64'(if_instr),    64'h13);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("misal_hold_valid", 64'(if_valid), 64'd0);
        end

        // ---- Access fault at the end of memory ----
        redirect_en = 1'b1;
        redirect_pc = 64'h1FF8;
        tick(1);
        redirect_en = 1'b0;
        tick(1);
        check("fault_e0_pc",  if_pc,           64'h1FF8);
        check("fault_e0_exc", 64'(if_exc_en),  64'd0);
        tick(1);
        check("fault_e1_pc",  if_pc,           64'h1FFC);
        check("fault_e1_exc", 64'(if_exc_en),  64'd0);
        tick(1);
        check("fault_e2_pc",       if_pc,            64'h2000);
        check("fault_e2_exc_en",   64'(if_exc_en),   64'd1);
        check("fault_e2_exc_code", 64'(if_exc_code), 64'd1);
        check("fault_e2_exc_val",  if_exc_val,       64'h2000);
        check("fault_e2_instr",    64'(if_instr),    64'h13);
        check("fault_e2_addr",     imem_addr,        64'h2000);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("fault_hold_valid", 64'(if_valid), 64'd0);
            check("fault_hold_addr",  imem_addr,     64'h2000);
        end

        // ---- Reset while HOLD with two buffered entries (redirect also asserted) ----
        if_ready = 1'b0;
        redirect_en = 1'b1;
        redirect_pc = 64'h1FFC;
        tick(1);
        redirect_en = 1'b0;
        tick(2);
        check("hold_full_pc",  if_pc,          64'h1FFC);
        check("hold_full_val", 64'(if_valid),  64'd1);
        rst = 1'b1;
        redirect_en = 1'b1;
        redirect_pc = 64'h100;
        tick(1);
        rst = 1'b0;
        redirect_en = 1'b0;
        check("rst_mid_valid", 64'(if_valid), 64'd0);
        check("rst_mid_addr",  imem_addr,     64'h0);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_mid_perf_stall", perf_stall, 64'd0);
`endif
        if_ready = 1'b1;
        tick(1);
        check("rst_resume_pc0", if_pc, 64'h0);
        tick(1);
        check("rst_resume_pc1", if_pc, 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch-side initiator for the combinational instruction memory.
- Owns the PC, drives the memory address, and samples the returned instruction and access-fault signals in the same cycle.
- Buffers fetched entries in a small FIFO and hands them to decode over a valid/ready handshake.
- Takes redirects from execute/trap logic.
- Stops fetching after any fetch exception until it is redirected.

Parameters:
- XLEN, 64, PC and exception-value width.
- RESET_PC, 64'h0, PC loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- imem_addr  out  XLEN  fetch address; equals the PC register.
- imem_instr  in  32  instruction word for imem_addr, same cycle.
- imem_exc_en  in  1  access fault for imem_addr, same cycle.
- imem_exc_code  in  4  fault cause; 1 = instruction access fault.
- imem_exc_val  in  XLEN  faulting address.
- redirect_en  in  1  load new PC and flush buffer.
- redirect_pc  in  XLEN  redirect target.
- if_valid  out  1  head entry valid.
- if_ready  in  1  decode accepts head entry.
- if_pc  out  XLEN  PC of head entry.
- if_instr  out  32  instruction of head entry.
- if_exc_en  out  1  head entry carries an exception.
- if_exc_code  out  4  head exception cause.
- if_exc_val  out  XLEN  head mtval value.

Behaviour:
- Reset:
  - pc=RESET_PC, state=FETCH, FIFO emptied, count=0.
  - if_valid=0; if_pc=0, if_instr=32'h00000013, exc outputs 0 (FIFO outputs zero/NOP when empty).
  - Reset asserted mid-operation discards all entries and any pending exception.
- States: FETCH, MISAL, HOLD.
- Push condition: push_ok = (count<FIFO_DEPTH) || pop, where pop = if_valid && if_ready.
  - Push and pop in the same cycle is allowed when full, giving 1 instr/cycle throughput.
- FETCH, push_ok, imem_exc_en=0:
  - Push {pc, imem_instr, exc=0}; pc <= pc+4.
  - pc wraps modulo 2^XLEN.
- FETCH, push_ok, imem_exc_en=1:
  - Push {pc, NOP 32'h00000013, exc=1, imem_exc_code, imem_exc_val}.
  - pc unchanged; state -> HOLD.
- FETCH, !push_ok: nothing pushed; pc held. imem_addr stays stable.
- MISAL, push_ok:
  - Push synthetic entry {pc, NOP, exc=1, code=0 (instruction address misaligned), val=pc}.
  - state -> HOLD.
- HOLD: no pushes; pc held. Remains until redirect_en.
- redirect_en (highest priority, any state):
  - FIFO flushed; pop ignored; no push that cycle.
  - pc <= redirect_pc.
  - state -> MISAL if redirect_pc[1:0]!=0, else FETCH.
  - The first fetch from the new PC happens the next cycle.
- redirect_en together with rst: rst wins.
- Output ordering:
  - if_* reflect the FIFO head combinationally from registered storage.
  - Entries pop in push order.
  - The exception entry is always the last entry before HOLD.
- Latency: redirect to if_valid = 2 cycles when decode is ready and memory returns no fault (cycle 1 loads pc, cycle 2 head valid).

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- When defined, add ports:
  - perf_fetched  out  64  count of non-exception entries pushed.
  - perf_stall  out  64  cycles in FETCH with !push_ok.
  - Both reset to 0, saturate at all-ones, and are not cleared by redirect.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package ifetch_pkg:
  - NOP constant 32'h00000013.
  - Exception codes EXC_INSTR_MISALIGNED=4'd0, EXC_INSTR_ACCESS=4'd1.
  - State encoding FETCH/MISAL/HOLD.
  - Entry field widths.
- Sub-module ifetch_fifo:
  - Parameterised synchronous FIFO with push/pop/flush, count, head outputs, and NOP-when-empty.
  - ifetch_unit holds the PC, state machine and push logic.

Test Plan:
- Reset then if_ready=1, clean memory -> cycle 1 onward if_valid=1 with if_pc 0x0, 0x4, 0x8, one per cycle; imem_addr advances by 4 per cycle.
- if_ready=0 for 5 cycles from reset:
  - FIFO fills to 2 entries (pc 0x0, 0x4); imem_addr holds 0x8; perf_stall=3 (if enabled).
  - After release, entries pop in order 0x0, 0x4, 0x8.
- Redirect to 0x100 while 2 entries are buffered -> FIFO empty the next cycle; first if_pc=0x100; old entries never presented.
- Redirect to 0x102 -> single entry with if_exc_en=1, if_exc_code=0, if_exc_val=0x102, if_instr=0x00000013; then if_valid=0 until the next redirect.
- Memory faults at 0x2000 (2048-word memory) after sequential fetch from 0x1FF8:
  - Entries 0x1FF8 and 0x1FFC are clean, then the entry at 0x2000 has exc_code=1, exc_val=0x2000.
  - imem_addr stays 0x2000 and no further entries appear.
- rst asserted for 1 cycle with 2 entries buffered and state HOLD -> if_valid=0, imem_addr=RESET_PC, fetch resumes at 0x0.
